fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue: byte-wide instruction fetcher that assembles big-endian words
// into a small FIFO for the decoder. Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]    state, state_nx;
  logic [63:0]   fetch_pc;
  logic [1:0]    byte_cnt, byte_cnt_nx;
  logic [23:0]   partial;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          accept, push, pop;

  logic [31:0] instr_q [DEPTH];
  logic [63:0] pc_q    [DEPTH];

  assign mem_req  = (state == FETCH) & reset;
  assign mem_addr = fetch_pc + {62'd0, byte_cnt};
  assign accept   = mem_req & mem_gnt;
  assign push     = accept & (byte_cnt == 2'd3);
  assign pop      = instr_valid & instr_ready;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? instr_q[rd_ptr] : 32'd0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr]    : 64'd0;

  // Stall only on a word boundary, so a word in flight always has a free slot.
  always_comb begin
    count_nx    = count + CW'(push) - CW'(pop);
    byte_cnt_nx = accept ? byte_cnt + 2'd1 : byte_cnt;
    state_nx    = ((count_nx == CW'(DEPTH)) && (byte_cnt_nx == 2'd0)) ? FULL : FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      byte_cnt <= 2'd0;
      partial  <= 24'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      state    <= FETCH;
      fetch_pc <= redirect_pc;
      byte_cnt <= 2'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      byte_cnt <= byte_cnt_nx;
      count    <= count_nx;
      if (accept) begin
        partial <= {partial[15:0], mem_rdata};
      end
      if (push) begin
        fetch_pc <= fetch_pc + 64'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      instr_q[wr_ptr] <= {partial, mem_rdata};
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue: directed scenarios plus random traffic against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_gnt = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        instr_ready = 1'b0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h2000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of finished words plus the bytes of the word in flight.
  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  int          m_nb;
  logic [7:0]  m_b [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_req();
    return (m_nb != 0) || (q.size() < DEPTH);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_nb = 0;
    m_pc = 64'h2000;
  endfunction

  function automatic void model_step(input bit g, input logic [7:0] d, input bit rdy,
                                     input bit rd, input logic [63:0] rpc);
    bit acc;
    bit popd;
    if (rd) begin
      q.delete();
      m_nb = 0;
      m_pc = rpc;
      return;
    end
    acc  = m_req() && g;
    popd = (q.size() != 0) && rdy;
    if (popd) void'(q.pop_front());
    if (acc) begin
      m_b[m_nb] = d;
      m_nb++;
      if (m_nb == 4) begin
        q.push_back('{w: {m_b[0], m_b[1], m_b[2], m_b[3]}, pc: m_pc});
        m_pc = m_pc + 64'd4;
        m_nb = 0;
      end
    end
  endfunction

  task automatic compare();
    check("mem_req", {63'd0, mem_req}, {63'd0, m_req()});
    check("mem_addr", mem_addr, m_pc + 64'(m_nb));
    check("instr_valid", {63'd0, instr_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("instr", {32'd0, instr}, {32'd0, q[0].w});
      check("instr_pc", instr_pc, q[0].pc);
    end
  endtask

  // Called at a falling edge: drive, advance the model, then compare at the next falling edge.
  task automatic cycle(input bit g, input logic [7:0] d, input bit rdy,
                       input bit rd, input logic [63:0] rpc);
    mem_gnt     = g;
    mem_rdata   = d;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    model_step(g, d, rdy, rd, rpc);
    @(negedge clk);
    compare();
  endtask

  logic [7:0]  bytes33 [4];
  logic [7:0]  bytes35 [4];
  logic [63:0] addr37 [4];
  logic [63:0] rpc;
  int          rdy_pct;

  initial begin
    bytes33 = '{8'hC8, 8'h42, 8'h00, 8'h05};
    bytes35 = '{8'h11, 8'h22, 8'h33, 8'h44};
    addr37  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_addr", mem_addr, 64'h2000);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_instr_pc", instr_pc, 64'd0);
    reset = 1'b1;
    #1;
    check("rel_mem_req", {63'd0, mem_req}, 64'd1);
    check("rel_addr", mem_addr, 64'h2000);
    @(negedge clk);

    // First word assembly and latency
    for (int k = 0; k < 4; k++) begin
      check("w0_addr", mem_addr, 64'h2000 + 64'(k));
      check("w0_valid_early", {63'd0, instr_valid}, 64'd0);
      cycle(1'b1, bytes33[k], 1'b0, 1'b0, 64'd0);
    end
    check("w0_valid", {63'd0, instr_valid}, 64'd1);
    check("w0_instr", {32'd0, instr}, 64'hC842_0005);
    check("w0_pc", instr_pc, 64'h2000);

    // Fill to DEPTH and stall
    for (int k = 0; k < 12; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 64'd0);
    check("full_req", {63'd0, mem_req}, 64'd0);
    repeat (3) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 64'd0);
    check("full_hold", {63'd0, mem_req}, 64'd0);
    check("full_head", instr_pc, 64'h2000);
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 64'd0);
    check("resume_req", {63'd0, mem_req}, 64'd1);
    check("resume_addr", mem_addr, 64'h2010);

    // Push and pop on the same edge
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 64'd0);
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 64'd0);
    check("pp_head", instr_pc, 64'h2008);
    check("pp_addr", mem_addr, 64'h2014);
    for (int k = 0; k < 3; k++) begin
      check("pp_order", instr_pc, 64'h2008 + 64'(4 * k));
      cycle(1'b0, 8'd0, 1'b1, 1'b0, 64'd0);
    end
    check("pp_drained", {63'd0, instr_valid}, 64'd0);

    // Redirect mid-word with two entries queued
    for (int k = 0; k < 10; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 64'd0);
    check("pre_redir_valid", {63'd0, instr_valid}, 64'd1);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 64'h3000);
    check("redir_valid", {63'd0, instr_valid}, 64'd0);
    check("redir_addr", mem_addr, 64'h3000);
    check("redir_req", {63'd0, mem_req}, 64'd1);
    for (int k = 0; k < 4; k++) cycle(1'b1, bytes35[k], 1'b0, 1'b0, 64'd0);
    check("redir_instr", {32'd0, instr}, 64'h1122_3344);
    check("redir_pc", instr_pc, 64'h3000);

    // Back-to-back redirects, last one wins
    cycle(1'b1, 8'h99, 1'b0, 1'b1, 64'h5000);
    cycle(1'b1, 8'h98, 1'b0, 1'b0, 64'd0);
    cycle(1'b1, 8'h97, 1'b0, 1'b1, 64'h6000);
    check("b2b_addr", mem_addr, 64'h6000);
    check("b2b_valid", {63'd0, instr_valid}, 64'd0);

    // Address wrap
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      check("wrap_addr", mem_addr, addr37[k]);
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 64'd0);
    end
    check("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_next", mem_addr, 64'h2);

    // Asynchronous reset mid-word during a grant stall
    cycle(1'b1, 8'h01, 1'b1, 1'b0, 64'd0);
    cycle(1'b1, 8'h02, 1'b1, 1'b0, 64'd0);
    cycle(1'b0, 8'h03, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 8'h03, 1'b0, 1'b0, 64'd0);
    #2 reset = 1'b0;
    #1;
    check("arst_req", {63'd0, mem_req}, 64'd0);
    check("arst_valid", {63'd0, instr_valid}, 64'd0);
    check("arst_addr", mem_addr, 64'h2000);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_rel_req", {63'd0, mem_req}, 64'd1);
    check("arst_rel_addr", mem_addr, 64'h2000);
    @(negedge clk);

    // Random traffic, low decoder readiness first to exercise the full path
    for (int n = 0; n < 3000; n++) begin
      rdy_pct = (n < 1500) ? 12 : 50;
      rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                        : {$urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 99) < 3, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
